alu_multicycle: RTL and testbench

- Parametrised successor to the single-cycle datapath ALU.
- Adds variable shifts, signed compare, and iterative unsigned multiply/divide with a start/busy/done handshake.
- Sits in the execute stage. The CPU stalls on busy for MUL/DIV.
- Operation codes 0000-1001 keep their existing meaning, so current control decode is unchanged.

---
 rtl/alu_multicycle_if.sv | 24 ++
 rtl/alu_multicycle.sv | 162 ++++++++++++++++
 tb/tb_alu_multicycle.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_multicycle_if.sv
// Request/response bundle between the execute-stage control and the multicycle ALU.
interface alu_multicycle_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [3:0]       alu_function;
   logic [WIDTH-1:0] alu_result;
   logic [WIDTH-1:0] hi_result;
   logic             zero;
   logic             busy;
   logic             done;

   modport master (
      output start, A, B, alu_function,
      input  alu_result, hi_result, zero, busy, done
   );

   modport slave (
      input  start, A, B, alu_function,
      output alu_result, hi_result, zero, busy, done
   );
endinterface

// File: rtl/alu_multicycle.sv
// Execute-stage ALU: single-cycle logic/arith/shift ops plus iterative
// unsigned multiply (shift-add) and divide (restoring), one bit per cycle.
module alu_multicycle #(
   parameter int unsigned WIDTH = 32
) (
   input logic              clk,
   input logic              reset,
   alu_multicycle_if.slave  bus
);
   localparam int unsigned SH_W    = $clog2(WIDTH);
   localparam logic [3:0]  OP_MULU = 4'b1010;
   localparam logic [3:0]  OP_DIVU = 4'b1011;

   typedef enum logic {IDLE, CALC} state_e;

   state_e           state, state_d;
   logic [SH_W-1:0]  cnt, cnt_d;
   logic [WIDTH-1:0] acc, acc_d;     // product high half / partial remainder
   logic [WIDTH-1:0] lo, lo_d;       // multiplier bits / dividend-quotient
   logic [WIDTH-1:0] opnd, opnd_d;   // multiplicand or divisor
   logic             is_mul, is_mul_d;
   logic [WIDTH-1:0] res_d, hi_d;
   logic             zero_d, busy_d, done_d;

   logic [WIDTH-1:0] simple_c;
   logic [SH_W-1:0]  sh_c;
   logic [WIDTH:0]   mul_sum_c;
   logic [WIDTH:0]   div_shift_c;
   logic [WIDTH-1:0] div_diff_c;
   logic [WIDTH-1:0] acc_step_c, lo_step_c;

   // Single-cycle result for the current request
   always_comb begin
      sh_c = bus.B[SH_W-1:0];
      case (bus.alu_function)
         4'b0000: simple_c = bus.A & bus.B;
         4'b0001: simple_c = bus.A | bus.B;
         4'b0010: simple_c = bus.A + bus.B;
         4'b0011: simple_c = bus.A ^ bus.B;
         4'b0100: simple_c = ~(bus.A ^ bus.B);
         4'b0101: simple_c = bus.A << 1;
         4'b0110: simple_c = bus.A - bus.B;
         4'b0111: simple_c = WIDTH'(bus.A < bus.B);
         4'b1000: simple_c = bus.A >> 1;
         4'b1001: simple_c = ~bus.A;
         4'b1100: simple_c = bus.A << sh_c;
         4'b1101: simple_c = bus.A >> sh_c;
         4'b1110: simple_c = WIDTH'($signed(bus.A) >>> sh_c);
         4'b1111: simple_c = WIDTH'($signed(bus.A) < $signed(bus.B));
         default: simple_c = '0;
      endcase
   end

   // One iteration of shift-add multiply or restoring divide
   always_comb begin
      mul_sum_c   = lo[0] ? ({1'b0, acc} + {1'b0, opnd}) : {1'b0, acc};
      div_shift_c = {acc, lo[WIDTH-1]};
      div_diff_c  = div_shift_c[WIDTH-1:0] - opnd;
      if (is_mul) begin
         acc_step_c = mul_sum_c[WIDTH:1];
         lo_step_c  = {mul_sum_c[0], lo[WIDTH-1:1]};
      end else if (div_shift_c >= {1'b0, opnd}) begin
         acc_step_c = div_diff_c;
         lo_step_c  = {lo[WIDTH-2:0], 1'b1};
      end else begin
         acc_step_c = div_shift_c[WIDTH-1:0];
         lo_step_c  = {lo[WIDTH-2:0], 1'b0};
      end
   end

   // Next-state and output logic
   always_comb begin
      state_d  = state;
      cnt_d    = cnt;
      acc_d    = acc;
      lo_d     = lo;
      opnd_d   = opnd;
      is_mul_d = is_mul;
      res_d    = bus.alu_result;
      hi_d     = bus.hi_result;
      busy_d   = bus.busy;
      done_d   = 1'b0;

      case (state)
         IDLE: begin
            if (bus.start) begin
               if (bus.alu_function == OP_MULU) begin
                  acc_d    = '0;
                  lo_d     = bus.B;
                  opnd_d   = bus.A;
                  is_mul_d = 1'b1;
                  cnt_d    = '0;
                  busy_d   = 1'b1;
                  state_d  = CALC;
               end else if (bus.alu_function == OP_DIVU) begin
                  if (bus.B == '0) begin
                     res_d  = '1;
                     hi_d   = bus.A;
                     done_d = 1'b1;
                  end else begin
                     acc_d    = '0;
                     lo_d     = bus.A;
                     opnd_d   = bus.B;
                     is_mul_d = 1'b0;
                     cnt_d    = '0;
                     busy_d   = 1'b1;
                     state_d  = CALC;
                  end
               end else begin
                  res_d  = simple_c;
                  hi_d   = '0;
                  done_d = 1'b1;
               end
            end
         end
         CALC: begin
            acc_d = acc_step_c;
            lo_d  = lo_step_c;
            cnt_d = cnt + SH_W'(1);
            if (cnt == SH_W'(WIDTH - 1)) begin
               res_d   = lo_step_c;
               hi_d    = acc_step_c;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               cnt_d   = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      zero_d = (res_d == '0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         cnt            <= '0;
         acc            <= '0;
         lo             <= '0;
         opnd           <= '0;
         is_mul         <= 1'b0;
         bus.alu_result <= '0;
         bus.hi_result  <= '0;
         bus.zero       <= 1'b1;
         bus.busy       <= 1'b0;
         bus.done       <= 1'b0;
      end else begin
         state          <= state_d;
         cnt            <= cnt_d;
         acc            <= acc_d;
         lo             <= lo_d;
         opnd           <= opnd_d;
         is_mul         <= is_mul_d;
         bus.alu_result <= res_d;
         bus.hi_result  <= hi_d;
         bus.zero       <= zero_d;
         bus.busy       <= busy_d;
         bus.done       <= done_d;
      end
   end
endmodule

// File: tb/tb_alu_multicycle.sv
// Randomized scoreboard bench for alu_multicycle: driver pushes expected
// results with their due cycle, monitor checks outputs every cycle.
module tb_alu_multicycle;
   localparam int unsigned W = 32;

   typedef struct {
      logic [W-1:0] res;
      logic [W-1:0] hi;
      int           due_cyc;
   } exp_t;

   logic clk;
   logic reset;
   alu_multicycle_if #(.WIDTH(W)) bus ();

   alu_multicycle #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   exp_t q[$];
   int   cyc      = 0;
   int   mc_start = 0;
   int   mc_end   = 0;
   int   n_checks = 0;
   int   n_fail   = 0;
   bit   mon_en   = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, expv);
      end
   endtask

   // Reference: {hi, result} straight from the opcode definitions
   function automatic logic [63:0] model(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      case (f)
         4'd0:  r = a & b;
         4'd1:  r = a | b;
         4'd2:  r = a + b;
         4'd3:  r = a ^ b;
         4'd4:  r = ~(a ^ b);
         4'd5:  r = a << 1;
         4'd6:  r = a - b;
         4'd7:  r = (a < b) ? 32'd1 : 32'd0;
         4'd8:  r = a >> 1;
         4'd9:  r = ~a;
         4'd10: return {32'd0, a} * {32'd0, b};
         4'd11: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
         4'd12: r = a << b[4:0];
         4'd13: r = a >> b[4:0];
         4'd14: r = 32'($signed(a) >>> b[4:0]);
         default: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      endcase
      return {32'd0, r};
   endfunction

   function automatic bit is_multi(input logic [3:0] f, input logic [31:0] b);
      return (f == 4'd10) || (f == 4'd11 && b != 0);
   endfunction

   // Monitor: every cycle compare busy/done, and data on each done
   initial begin
      exp_t e;
      bit   exp_done;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         if (mon_en) begin
            check("busy", 64'(bus.busy), 64'(cyc >= mc_start && cyc < mc_end));
            exp_done = (q.size() > 0) && (q[0].due_cyc == cyc);
            check("done", 64'(bus.done), 64'(exp_done));
            if (exp_done) begin
               e = q.pop_front();
               if (bus.done) begin
                  check("alu_result", 64'(bus.alu_result), 64'(e.res));
                  check("hi_result", 64'(bus.hi_result), 64'(e.hi));
                  check("zero", 64'(bus.zero), 64'(e.res == 0));
               end
            end
         end
      end
   end

   task automatic issue(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] m;
      exp_t        e;
      @(negedge clk);
      bus.start        = 1'b1;
      bus.alu_function = f;
      bus.A            = a;
      bus.B            = b;
      m         = model(f, a, b);
      e.res     = m[31:0];
      e.hi      = m[63:32];
      e.due_cyc = is_multi(f, b) ? cyc + 33 : cyc + 1;
      if (is_multi(f, b)) begin
         mc_start = cyc + 1;
         mc_end   = cyc + 33;
      end
      q.push_back(e);
   endtask

   // Drop start, scramble idle inputs, and wait (bounded) for the queue to drain
   task automatic idle_wait();
      @(negedge clk);
      bus.start = 1'b0;
      for (int i = 0; i < 80 && q.size() != 0; i++) begin
         bus.A            = $urandom;
         bus.B            = $urandom;
         bus.alu_function = 4'($urandom_range(0, 15));
         @(negedge clk);
      end
      check("drain", 64'(q.size()), 64'd0);
      q.delete();
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_alu_result"}, 64'(bus.alu_result), 64'd0);
      check({tag, "_hi_result"}, 64'(bus.hi_result), 64'd0);
      check({tag, "_zero"}, 64'(bus.zero), 64'd1);
      check({tag, "_busy"}, 64'(bus.busy), 64'd0);
      check({tag, "_done"}, 64'(bus.done), 64'd0);
   endtask

   initial begin
      int          t0;
      logic [3:0]  f;
      logic [31:0] a, b;

      reset            = 1'b1;
      bus.start        = 1'b0;
      bus.A            = '0;
      bus.B            = '0;
      bus.alu_function = '0;
      repeat (3) @(negedge clk);
      check_reset_vals("reset");
      reset  = 1'b0;
      mon_en = 1;

      issue(4'd2, 32'hFFFF_FFFF, 32'h1);
      idle_wait();
      issue(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      idle_wait();
      issue(4'd11, 32'd100, 32'd7);
      idle_wait();
      issue(4'd11, 32'd5, 32'd0);
      idle_wait();

      // Back-to-back single-cycle ops
      issue(4'd14, 32'h8000_0000, 32'd4);
      issue(4'd13, 32'h8000_0000, 32'd4);
      issue(4'd15, 32'hFFFF_FFFF, 32'd1);
      issue(4'd7, 32'hFFFF_FFFF, 32'd1);
      idle_wait();

      // A start during CALC must be ignored
      issue(4'd10, 32'd3, 32'd5);
      t0 = cyc;
      @(negedge clk);
      bus.start = 1'b0;
      while (cyc < t0 + 10) @(negedge clk);
      bus.start        = 1'b1;
      bus.alu_function = 4'd2;
      bus.A            = 32'd1;
      bus.B            = 32'd1;
      @(negedge clk);
      bus.start = 1'b0;
      idle_wait();

      // Reset mid-CALC aborts without a done pulse
      issue(4'd10, 32'd7, 32'd9);
      t0 = cyc;
      @(negedge clk);
      bus.start = 1'b0;
      while (cyc < t0 + 12) @(negedge clk);
      reset  = 1'b1;
      q.delete();
      mc_end = 0;
      @(negedge clk);
      check_reset_vals("abort");
      reset = 1'b0;
      issue(4'd2, 32'd2, 32'd3);
      idle_wait();

      // Randomized mix, with occasional small/zero divisors
      for (int i = 0; i < 60; i++) begin
         f = 4'($urandom_range(0, 15));
         a = $urandom;
         b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
         issue(f, a, b);
         if (is_multi(f, b) || $urandom_range(0, 3) == 0) idle_wait();
      end
      idle_wait();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
